// File: rtl/lsu_mem_stage_pkg.sv
// Shared constants and types for the load/store memory stage.
// Holds funct3 encodings, FSM state type, error codes and lane helpers.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  function automatic logic legal_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Size lives in funct3[1:0] for both loads and stores.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/ready bus between the memory stage and the data memory.
interface lsu_mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ready, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/lsu_mem_stage_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_BU:   result = {24'h0, b};
      F3_HU:   result = {16'h0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: request/ready handshake with data memory, lane steering,
// load extension, pipeline stall and misaligned/illegal/timeout error reporting.
//
//  state | meaning
//  IDLE  | waiting for a load/store; legal aligned request accepted here
//  REQ   | dmem_req held until dmem_ready or timer expiry
//  DONE  | stall released, load_valid/err pulse, enables ignored
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err,
  output logic [1:0]  err_code,
  lsu_mem_stage_if.master dmem
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  lsu_state_t state_q, state_d;

  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [TW-1:0] tmr_q;

  logic        rd_only, wr_only, any_en;
  logic        illegal, misalign, req_ok, req_bad;
  logic        accept, complete, expire;
  logic [31:0] load_ext;

  always_comb begin
    rd_only  = mem_read_en & ~mem_write_en;
    wr_only  = mem_write_en & ~mem_read_en;
    any_en   = mem_read_en | mem_write_en;
    illegal  = (mem_read_en & mem_write_en) |
               (rd_only & ~legal_load(funct3)) |
               (wr_only & ~legal_store(funct3));
    misalign = ((funct3[1:0] == 2'b01) & alu_result[0]) |
               ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00));
    req_ok   = any_en & ~illegal & ~misalign;
    req_bad  = any_en & (illegal | misalign);
  end

  // Ready wins over expiry when both land in the same REQ cycle.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem.ready) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (tmr_q == TMR_ONE)) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      tmr_q   <= '0;
    end else if (accept) begin
      addr_q  <= {alu_result[31:2], 2'b00};
      be_q    <= byte_enables(funct3, alu_result[1:0]);
      wdata_q <= store_lanes(funct3, rs2_data);
      we_q    <= mem_write_en;
      f3_q    <= funct3;
      off_q   <= alu_result[1:0];
      tmr_q   <= TMR_LOAD;
    end else if ((state_q == REQ) && !dmem.ready && (TIMEOUT_CYCLES != 0)) begin
      tmr_q   <= tmr_q - TMR_ONE;
    end
  end

  lsu_load_align u_align (
    .rdata  (dmem.rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data  <= '0;
      load_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      load_valid <= 1'b0;
      err        <= 1'b0;
      if (complete && !we_q) begin
        load_data  <= load_ext;
        load_valid <= 1'b1;
      end
      if (expire) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if ((state_q == IDLE) && req_bad) begin
        err      <= 1'b1;
        err_code <= illegal ? ERR_ILLEGAL : ERR_MISALIGN;
      end
    end
  end

  assign dmem.req   = (state_q == REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes expected bus/load/err
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  localparam int K_REQ = 0;
  localparam int K_LOAD = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rs2_data;
  logic        stall, load_valid, err;
  logic [31:0] load_data;
  logic [1:0]  err_code;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic req_prev = 1'b0;

  lsu_mem_stage_if dmem ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .funct3       (funct3),
    .alu_result   (alu_result),
    .rs2_data     (rs2_data),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .err          (err),
    .err_code     (err_code),
    .dmem         (dmem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic we);
    exp_t e;
    e.kind = kind; e.a = a; e.be = be; e.wd = wd; e.we = we;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic we);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: kind %0d data %h with empty queue", kind, a);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.a !== a || e.be !== be || e.wd !== wd || e.we !== we) begin
        n_bad++;
        $display("FAIL event: got kind %0d a %h be %b wd %h we %b expected kind %0d a %h be %b wd %h we %b",
                 kind, a, be, wd, we, e.kind, e.a, e.be, e.wd, e.we);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (dmem.req && !req_prev) pop_cmp(K_REQ, dmem.addr, dmem.be, dmem.wdata, dmem.we);
      if (load_valid) pop_cmp(K_LOAD, load_data, 4'h0, 32'h0, 1'b0);
      if (err) pop_cmp(K_ERR, {30'h0, err_code}, 4'h0, 32'h0, 1'b0);
      req_prev = dmem.req;
    end
  end

  // rdy_at: REQ cycle number (1 = first) in which dmem_ready is driven; 0 = never.
  task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input int rdy_at, input logic [31:0] rdata, input int exp_stall);
    int  stall_cnt = 0;
    int  req_cnt = 0;
    bit  released = 0;
    @(posedge clk); #1;
    mem_read_en = rd; mem_write_en = wr; funct3 = f3; alu_result = addr; rs2_data = rs2;
    for (int cyc = 0; cyc < 64; cyc++) begin
      dmem.ready = (rdy_at > 0) && (cyc == rdy_at);
      dmem.rdata = dmem.ready ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (dmem.req) req_cnt++;
      if (!stall) begin
        released = 1;
        break;
      end
      stall_cnt++;
      @(posedge clk); #1;
    end
    if (!released) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_stall_release: stall still 1 after 64 cycles", nm);
    end
    @(posedge clk); #1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; dmem.ready = 1'b0;
    chk({nm, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({nm, "_req_cycles"}, req_cnt, (exp_stall > 0) ? exp_stall - 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; funct3 = 3'b000;
    alu_result = '0; rs2_data = '0;
    dmem.ready = 1'b0; dmem.rdata = '0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_req", dmem.req, 0);
    chk("rst_we", dmem.we, 0);
    chk("rst_addr", dmem.addr, 0);
    chk("rst_be", dmem.be, 0);
    chk("rst_wdata", dmem.wdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    push(K_REQ, 32'h100, 4'b1111, 32'h1111_1111, 1'b0); push(K_LOAD, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("lw", 1, 0, F3_W, 32'h100, 32'h1111_1111, 3, 32'hDEAD_BEEF, 4);

    push(K_REQ, 32'h100, 4'b1000, 32'h0, 1'b0); push(K_LOAD, 32'hFFFF_FF80, 0, 0, 0);
    run_op("lb", 1, 0, F3_B, 32'h103, 32'h0, 1, 32'h80FF_0000, 2);

    push(K_REQ, 32'h100, 4'b1000, 32'h0, 1'b0); push(K_LOAD, 32'h0000_0080, 0, 0, 0);
    run_op("lbu", 1, 0, F3_BU, 32'h103, 32'h0, 1, 32'h80FF_0000, 2);

    push(K_REQ, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1);
    run_op("sh", 0, 1, F3_H, 32'h202, 32'h1234_ABCD, 2, 32'h0, 3);

    push(K_REQ, 32'h100, 4'b1100, 32'hBEEF_BEEF, 1'b0); push(K_LOAD, 32'hFFFF_8001, 0, 0, 0);
    run_op("lh", 1, 0, F3_H, 32'h102, 32'h0000_BEEF, 1, 32'h8001_7FFF, 2);

    push(K_REQ, 32'h100, 4'b0011, 32'h0, 1'b0); push(K_LOAD, 32'h0000_7FFF, 0, 0, 0);
    run_op("lhu", 1, 0, F3_HU, 32'h100, 32'h0, 2, 32'h8001_7FFF, 3);

    push(K_REQ, 32'h300, 4'b0010, 32'hA5A5_A5A5, 1'b1);
    run_op("sb", 0, 1, F3_B, 32'h301, 32'h0000_00A5, 1, 32'h0, 2);

    push(K_REQ, 32'h404, 4'b1111, 32'hCAFE_F00D, 1'b1);
    run_op("sw", 0, 1, F3_W, 32'h404, 32'hCAFE_F00D, 1, 32'h0, 2);

    push(K_ERR, {30'h0, ERR_MISALIGN}, 0, 0, 0);
    run_op("lw_mis", 1, 0, F3_W, 32'h101, 32'h0, 0, 32'h0, 0);
    push(K_ERR, {30'h0, ERR_MISALIGN}, 0, 0, 0);
    run_op("sh_mis", 0, 1, F3_H, 32'h203, 32'h0, 0, 32'h0, 0);
    push(K_ERR, {30'h0, ERR_ILLEGAL}, 0, 0, 0);
    run_op("rd_wr", 1, 1, F3_W, 32'h100, 32'h0, 0, 32'h0, 0);
    push(K_ERR, {30'h0, ERR_ILLEGAL}, 0, 0, 0);
    run_op("ld_f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0);
    push(K_ERR, {30'h0, ERR_ILLEGAL}, 0, 0, 0);
    run_op("st_f3_100", 0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 0);
    push(K_ERR, {30'h0, ERR_ILLEGAL}, 0, 0, 0);
    run_op("ill_over_mis", 1, 0, 3'b111, 32'h101, 32'h0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1 chk("err_code_hold_ill", err_code, 2'b11);

    push(K_REQ, 32'h500, 4'b1111, 32'h7777_0000, 1'b0); push(K_ERR, {30'h0, ERR_TIMEOUT}, 0, 0, 0);
    run_op("timeout", 1, 0, F3_W, 32'h500, 32'h7777_0000, 0, 32'h0, 5);
    repeat (3) @(posedge clk);
    #1 chk("err_code_hold_to", err_code, 2'b10);

    // dmem_ready while idle must not produce any event
    @(posedge clk); #1 dmem.ready = 1'b1; dmem.rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 dmem.ready = 1'b0;
    chk("idle_ready_stall", stall, 0);

    push(K_REQ, 32'h700, 4'b1111, 32'h0, 1'b0);
    @(posedge clk); #1;
    mem_read_en = 1'b1; funct3 = F3_W; alu_result = 32'h700; rs2_data = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", dmem.req, 1);
    reset = 1'b1; mem_read_en = 1'b0;
    #1;
    chk("mid_rst_req", dmem.req, 0);
    chk("mid_rst_stall", stall, 0);
    @(posedge clk); #1 reset = 1'b0;

    push(K_REQ, 32'h600, 4'b1111, 32'h0, 1'b0); push(K_LOAD, 32'h1357_9BDF, 0, 0, 0);
    run_op("lw_after_rst", 1, 0, F3_W, 32'h600, 32'h0, 1, 32'h1357_9BDF, 2);

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
